// File: rtl/regfile_bist.sv
// Built-in self-test engine for the 32x64 register file.
// Each run has two passes. Pass 0 uses r*PATTERN_MULT and pass 1 uses its
// bitwise inverse. A pass first tries to write the hardwired-zero register
// X31, then writes X0..X30, then reads all registers back through both read
// ports. Mismatches are counted, and the first failing register is latched.
// All regfile-side outputs and status outputs are registered.
module regfile_bist #(
  parameter logic [63:0] PATTERN_MULT = 64'h0000010204080001,
  parameter int unsigned NREGS        = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [7:0]  fail_count,
  output logic [4:0]  first_fail_reg,
  output logic        RegWrite,
  output logic [4:0]  WriteRegister,
  output logic [63:0] WriteData,
  output logic [4:0]  ReadRegister1,
  output logic [4:0]  ReadRegister2,
  input  logic [63:0] ReadData1,
  input  logic [63:0] ReadData2
);

  localparam logic [4:0] LAST_REG = 5'(NREGS - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_W31   = 3'd1,
    ST_WRITE = 3'd2,
    ST_READ  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Pattern written to register r. When inv is set, the pattern is inverted.
  function automatic logic [63:0] pattern_f(input logic inv, input logic [4:0] r);
    logic [63:0] base;
    base      = {59'd0, r} * PATTERN_MULT;
    pattern_f = inv ? ~base : base;
  endfunction

  // Value expected on read-back. The hardwired-zero register always reads 0.
  function automatic logic [63:0] expect_f(input logic inv, input logic [4:0] r);
    expect_f = (r == LAST_REG) ? 64'd0 : pattern_f(inv, r);
  endfunction

  state_t      state_q, state_d;
  logic        phase_q, phase_d;
  logic [4:0]  idx_q, idx_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic [7:0]  fail_count_q, fail_count_d;
  logic [4:0]  first_fail_q, first_fail_d;
  logic        regwrite_q, regwrite_d;
  logic [4:0]  wreg_q, wreg_d;
  logic [63:0] wdata_q, wdata_d;
  logic [4:0]  rreg1_q, rreg1_d;
  logic [4:0]  rreg2_q, rreg2_d;
  logic        mm1_s, mm2_s;

  // State register plus registered outputs. Reset is synchronous and active-low.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      phase_q      <= 1'b0;
      idx_q        <= 5'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_count_q <= 8'd0;
      first_fail_q <= 5'd0;
      regwrite_q   <= 1'b0;
      wreg_q       <= 5'd0;
      wdata_q      <= 64'd0;
      rreg1_q      <= 5'd0;
      rreg2_q      <= 5'd0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      idx_q        <= idx_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      fail_count_q <= fail_count_d;
      first_fail_q <= first_fail_d;
      regwrite_q   <= regwrite_d;
      wreg_q       <= wreg_d;
      wdata_q      <= wdata_d;
      rreg1_q      <= rreg1_d;
      rreg2_q      <= rreg2_d;
    end
  end

  // Next-state and next-output logic. Outputs are computed one cycle ahead
  // so that they are valid throughout the state they belong to.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    idx_d        = idx_q;
    busy_d       = busy_q;
    done_d       = done_q;
    pass_d       = pass_q;
    fail_count_d = fail_count_q;
    first_fail_d = first_fail_q;
    regwrite_d   = 1'b0;
    wreg_d       = wreg_q;
    wdata_d      = wdata_q;
    rreg1_d      = rreg1_q;
    rreg2_d      = rreg2_q;
    mm1_s        = 1'b0;
    mm2_s        = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d      = ST_W31;
          phase_d      = 1'b0;
          idx_d        = 5'd0;
          busy_d       = 1'b1;
          done_d       = 1'b0;
          pass_d       = 1'b0;
          fail_count_d = 8'd0;
          first_fail_d = 5'd0;
          regwrite_d   = 1'b1;
          wreg_d       = LAST_REG;
          wdata_d      = pattern_f(1'b0, LAST_REG);
        end else begin
          state_d = state_q;
        end
      end

      ST_W31: begin
        state_d    = ST_WRITE;
        idx_d      = 5'd0;
        regwrite_d = 1'b1;
        wreg_d     = 5'd0;
        wdata_d    = pattern_f(phase_q, 5'd0);
      end

      ST_WRITE: begin
        if (idx_q == LAST_REG - 5'd1) begin
          state_d    = ST_READ;
          idx_d      = 5'd0;
          regwrite_d = 1'b0;
          rreg1_d    = 5'd0;
          rreg2_d    = LAST_REG;
        end else begin
          idx_d      = idx_q + 5'd1;
          regwrite_d = 1'b1;
          wreg_d     = idx_q + 5'd1;
          wdata_d    = pattern_f(phase_q, idx_q + 5'd1);
        end
      end

      ST_READ: begin
        // Port 1 reads X[idx]; port 2 reads the mirrored register X[31-idx].
        mm1_s        = (ReadData1 != expect_f(phase_q, idx_q));
        mm2_s        = (ReadData2 != expect_f(phase_q, LAST_REG - idx_q));
        fail_count_d = fail_count_q + {7'd0, mm1_s} + {7'd0, mm2_s};
        // The count never wraps within a run, so a zero count means no
        // failure has been latched yet.
        if ((fail_count_q == 8'd0) && mm1_s) begin
          first_fail_d = idx_q;
        end else if ((fail_count_q == 8'd0) && mm2_s) begin
          first_fail_d = LAST_REG - idx_q;
        end else begin
          first_fail_d = first_fail_q;
        end

        if (idx_q == LAST_REG) begin
          if (!phase_q) begin
            state_d    = ST_W31;
            phase_d    = 1'b1;
            regwrite_d = 1'b1;
            wreg_d     = LAST_REG;
            wdata_d    = pattern_f(1'b1, LAST_REG);
          end else begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (fail_count_d == 8'd0);
          end
        end else begin
          idx_d   = idx_q + 5'd1;
          rreg1_d = idx_q + 5'd1;
          rreg2_d = LAST_REG - idx_q - 5'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign fail_count     = fail_count_q;
  assign first_fail_reg = first_fail_q;
  assign RegWrite       = regwrite_q;
  assign WriteRegister  = wreg_q;
  assign WriteData      = wdata_q;
  assign ReadRegister1  = rreg1_q;
  assign ReadRegister2  = rreg2_q;

endmodule

// File: tb/tb_regfile_bist.sv
// Directed testbench for regfile_bist.
// It contains a register-file model with selectable faults:
//   mode 0 - correct regfile
//   mode 1 - X31 can be written
//   mode 2 - X5 bit 0 is stuck at 0
module tb_regfile_bist;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        busy, done, pass;
  logic [7:0]  fail_count;
  logic [4:0]  first_fail_reg;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [63:0] WriteData;
  logic [4:0]  ReadRegister1, ReadRegister2;
  logic [63:0] ReadData1, ReadData2;

  logic [63:0] mem [32];
  int          fault_mode;
  logic        clr_mem;
  int          n_cmp;
  int          n_fail;
  int          cyc;

  regfile_bist dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .fail_count     (fail_count),
    .first_fail_reg (first_fail_reg),
    .RegWrite       (RegWrite),
    .WriteRegister  (WriteRegister),
    .WriteData      (WriteData),
    .ReadRegister1  (ReadRegister1),
    .ReadRegister2  (ReadRegister2),
    .ReadData1      (ReadData1),
    .ReadData2      (ReadData2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register-file model: writes are synchronous, reads are combinational.
  always @(posedge clk) begin
    if (clr_mem) begin
      for (int i = 0; i < 32; i++) mem[i] <= 64'd0;
    end else if (RegWrite && ((WriteRegister != 5'd31) || (fault_mode == 1))) begin
      if ((fault_mode == 2) && (WriteRegister == 5'd5))
        mem[WriteRegister] <= {WriteData[63:1], 1'b0};
      else
        mem[WriteRegister] <= WriteData;
    end
  end

  assign ReadData1 = mem[ReadRegister1];
  assign ReadData2 = mem[ReadRegister2];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // After this task, cycle 1 (the W31 cycle) is visible on the outputs.
  task automatic start_run();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
  endtask

  task automatic step_to(input int target);
    while (cyc < target) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic clear_mem();
    clr_mem = 1'b1;
    @(negedge clk);
    clr_mem = 1'b0;
  endtask

  task automatic run_and_check(input string tag, input logic exp_pass,
                               input logic [7:0] exp_cnt, input logic [4:0] exp_first);
    start_run();
    check({tag, "_c1_cnt_clear"}, {56'd0, fail_count}, 64'd0);
    check({tag, "_c1_done_low"}, {63'd0, done}, 64'd0);
    step_to(128);
    check({tag, "_c128_busy"}, {63'd0, busy}, 64'd1);
    step_to(129);
    check({tag, "_done"}, {63'd0, done}, 64'd1);
    check({tag, "_busy_low"}, {63'd0, busy}, 64'd0);
    check({tag, "_pass"}, {63'd0, pass}, {63'd0, exp_pass});
    check({tag, "_fail_count"}, {56'd0, fail_count}, {56'd0, exp_cnt});
    check({tag, "_first_fail"}, {59'd0, first_fail_reg}, {59'd0, exp_first});
  endtask

  initial begin
    n_cmp      = 0;
    n_fail     = 0;
    cyc        = 0;
    fault_mode = 0;
    clr_mem    = 1'b1;
    start      = 1'b0;
    reset_n    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    clr_mem = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_pass", {63'd0, pass}, 64'd0);
    check("rst_regwrite", {63'd0, RegWrite}, 64'd0);
    check("rst_fail_count", {56'd0, fail_count}, 64'd0);
    check("rst_first_fail", {59'd0, first_fail_reg}, 64'd0);
    check("rst_wreg", {59'd0, WriteRegister}, 64'd0);
    check("rst_wdata", WriteData, 64'd0);
    check("rst_rreg1", {59'd0, ReadRegister1}, 64'd0);
    check("rst_rreg2", {59'd0, ReadRegister2}, 64'd0);
    reset_n = 1'b1;

    // Good regfile: detailed timeline checks
    start_run();
    check("good_w31_busy", {63'd0, busy}, 64'd1);
    check("good_w31_we", {63'd0, RegWrite}, 64'd1);
    check("good_w31_wreg", {59'd0, WriteRegister}, 64'd31);
    check("good_w31_wdata", WriteData, 64'h00001F3E7CF8001F);
    step_to(4);
    check("good_wr2_wreg", {59'd0, WriteRegister}, 64'd2);
    check("good_wr2_wdata", WriteData, 64'h0000020408100002);
    step_to(33);
    check("good_rd0_we", {63'd0, RegWrite}, 64'd0);
    check("good_rd0_rr1", {59'd0, ReadRegister1}, 64'd0);
    check("good_rd0_rr2", {59'd0, ReadRegister2}, 64'd31);
    step_to(65);
    check("good_p1_w31_wdata", WriteData, 64'hFFFFE0C18307FFE0);
    step_to(68);
    check("good_p1_wr2_wdata", WriteData, 64'hFFFFFDFBF7EFFFFD);
    step_to(128);
    check("good_c128_busy", {63'd0, busy}, 64'd1);
    check("good_c128_done", {63'd0, done}, 64'd0);
    step_to(129);
    check("good_done", {63'd0, done}, 64'd1);
    check("good_busy", {63'd0, busy}, 64'd0);
    check("good_pass", {63'd0, pass}, 64'd1);
    check("good_fail_count", {56'd0, fail_count}, 64'd0);
    check("good_first_fail", {59'd0, first_fail_reg}, 64'd0);
    step_to(135);
    check("good_done_held", {63'd0, done}, 64'd1);

    // X31 can be written
    fault_mode = 1;
    clear_mem();
    run_and_check("x31w", 1'b0, 8'd4, 5'd31);

    // Restart from DONE with pass=0 against a correct regfile
    fault_mode = 0;
    clear_mem();
    run_and_check("rerun", 1'b1, 8'd0, 5'd0);

    // X5 bit 0 stuck at 0
    fault_mode = 2;
    clear_mem();
    run_and_check("x5sa0", 1'b0, 8'd2, 5'd5);

    // A start pulse during the run is ignored
    fault_mode = 0;
    clear_mem();
    start_run();
    step_to(20);
    start = 1'b1;
    step_to(21);
    start = 1'b0;
    step_to(128);
    check("ign_c128_busy", {63'd0, busy}, 64'd1);
    check("ign_c128_done", {63'd0, done}, 64'd0);
    step_to(129);
    check("ign_done", {63'd0, done}, 64'd1);
    check("ign_pass", {63'd0, pass}, 64'd1);
    check("ign_fail_count", {56'd0, fail_count}, 64'd0);

    // Mid-run reset; the stuck bit makes fail_count nonzero before the reset
    fault_mode = 2;
    clear_mem();
    start_run();
    step_to(39);
    check("mrst_pre_cnt", {56'd0, fail_count}, 64'd1);
    step_to(40);
    reset_n = 1'b0;
    step_to(41);
    reset_n = 1'b1;
    check("mrst_we", {63'd0, RegWrite}, 64'd0);
    check("mrst_busy", {63'd0, busy}, 64'd0);
    check("mrst_done", {63'd0, done}, 64'd0);
    check("mrst_cnt", {56'd0, fail_count}, 64'd0);
    check("mrst_first", {59'd0, first_fail_reg}, 64'd0);
    fault_mode = 0;
    clear_mem();
    run_and_check("postrst", 1'b1, 8'd0, 5'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
